// File: rtl/boot_loader_if.sv
// Bus bundle between a boot-stream source and the boot loader: byte input
// handshake, reload request, RAM write port and status flags.
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  reload;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        output in_valid, in_data, reload,
        input  in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, error
    );

    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Boot-stream loader: parses [len_hi, len_lo, payload..., checksum], writes the
// payload to RAM from address 0 and releases the CPU only on a good checksum.
module boot_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LOAD_DEPTH = 256
) (
    input logic          clk,
    input logic          reset,
    boot_loader_if.slave bus
);
    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t                state_reg, state_next;
    logic [15:0]           length_reg, length_next;
    logic [15:0]           pointer_reg, pointer_next;
    logic [DATA_WIDTH-1:0] sum_reg, sum_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  we_reg, we_next;
    logic                  accept;
    logic [15:0]           length_full;

    assign bus.in_ready = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                          (state_reg == DATA)   || (state_reg == CSUM);
    assign accept       = bus.in_valid && bus.in_ready;
    // Complete length as it will be once the low byte is taken this cycle.
    assign length_full  = {length_reg[15:8], bus.in_data[7:0]};

    always_comb begin
        state_next   = state_reg;
        length_next  = length_reg;
        pointer_next = pointer_reg;
        sum_next     = sum_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        we_next      = 1'b0;
        case (state_reg)
            LEN_HI: begin
                if (accept) begin
                    length_next[15:8] = bus.in_data[7:0];
                    state_next        = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    length_next  = length_full;
                    sum_next     = '0;
                    pointer_next = '0;
                    if (int'(length_full) > LOAD_DEPTH) begin
                        state_next = ERROR;
                    end else if (length_full == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    addr_next    = ADDR_WIDTH'(pointer_reg);
                    wdata_next   = bus.in_data;
                    we_next      = 1'b1;
                    sum_next     = sum_reg + bus.in_data;
                    pointer_next = pointer_reg + 16'd1;
                    if (pointer_reg == length_reg - 16'd1) begin
                        state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = (bus.in_data == sum_reg) ? DONE : ERROR;
                end
            end
            DONE, ERROR: begin
                if (bus.reload) begin
                    state_next = LEN_HI;
                end
            end
            default: state_next = LEN_HI;
        endcase
    end

    // Async reset also kills a write pulse registered on the previous edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= LEN_HI;
            length_reg  <= '0;
            pointer_reg <= '0;
            sum_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            length_reg  <= length_next;
            pointer_reg <= pointer_next;
            sum_reg     <= sum_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            we_reg      <= we_next;
        end
    end

    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.mem_we    = we_reg;
    assign bus.cpu_hold  = (state_reg != DONE);
    assign bus.done      = (state_reg == DONE);
    assign bus.error     = (state_reg == ERROR);
endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: directed and random boot streams, expected
// writes/status derived from the stream format and checked by a monitor.
module tb_boot_loader;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b0;

    boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    always #5 clk = ~clk;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          n_writes = 0;
    logic [23:0] exp_wr[$];   // {addr, data}
    logic [2:0]  exp_st[$];   // {done, error, cpu_hold}
    logic [7:0]  ram[0:65535];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: interpret the stream by its format rules.
    task automatic model_push(input bq_t s);
        int len;
        int sum;
        len = int'({s[0], s[1]});
        if (len > DEPTH) begin
            exp_st.push_back(3'b011);
            return;
        end
        sum = 0;
        for (int i = 0; i < len; i++) begin
            exp_wr.push_back({16'(i), s[2 + i]});
            sum = sum + int'(s[2 + i]);
        end
        exp_st.push_back((s[2 + len] == 8'(sum % 256)) ? 3'b100 : 3'b011);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bif.in_data  = b;
        bif.in_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            ok = bif.in_ready;
            @(negedge clk);
        end
        bif.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: byte %0h not accepted, in_ready 0, required 1", b);
        end
    endtask

    task automatic idle_cycle();
        bif.reload = 1'($urandom_range(0, 1));
        @(negedge clk);
        bif.reload = 1'b0;
    endtask

    task automatic send_stream(input bq_t s, input bit gappy);
        model_push(s);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (gappy && i < s.size() - 1) repeat ($urandom_range(0, 2)) idle_cycle();
        end
    endtask

    task automatic wait_finish(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (bif.done || bif.error) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: done/error 0, required 1", name);
        end
    endtask

    task automatic reload_pulse();
        bif.reload = 1'b1;
        @(negedge clk);
        bif.reload = 1'b0;
        check("reload_done", 32'(bif.done), 0);
        check("reload_error", 32'(bif.error), 0);
        check("reload_hold", 32'(bif.cpu_hold), 1);
        check("reload_ready", 32'(bif.in_ready), 1);
    endtask

    // Monitor: pops expected writes on every mem_we and expected status on every finish.
    initial begin : monitor
        logic [23:0] w;
        logic        fin;
        logic        fin_prev;
        fin_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, required no write",
                             bif.mem_addr, bif.mem_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(bif.mem_addr), 32'(w[23:8]));
                    check("wr_data", 32'(bif.mem_wdata), 32'(w[7:0]));
                end
                ram[bif.mem_addr] = bif.mem_wdata;
                n_writes++;
            end
            fin = bif.done | bif.error;
            if (fin && !fin_prev) begin
                check("wr_drained", 32'(exp_wr.size()), 0);
                if (exp_st.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_status: done %0b error %0b, required no finish",
                             bif.done, bif.error);
                end else begin
                    check("status", 32'({bif.done, bif.error, bif.cpu_hold}), 32'(exp_st.pop_front()));
                end
            end
            fin_prev = fin;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bq_t s;
        int  len;
        int  sum;
        int  wr_base;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        bif.reload   = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_hold", 32'(bif.cpu_hold), 1);
        check("rst_we", 32'(bif.mem_we), 0);
        check("rst_done", 32'(bif.done), 0);
        check("rst_error", 32'(bif.error), 0);
        check("rst_addr", 32'(bif.mem_addr), 0);
        check("rst_wdata", 32'(bif.mem_wdata), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 32'(bif.in_ready), 1);

        // Three-byte load, good checksum, back-to-back.
        s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_stream(s, 1'b0);
        wait_finish("good3");
        check("good3_hold", 32'(bif.cpu_hold), 0);

        // Bad checksum.
        reload_pulse();
        s = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'h00};
        send_stream(s, 1'b0);
        wait_finish("badcs");
        check("badcs_error", 32'(bif.error), 1);

        // Length 257 exceeds depth: error right after the length.
        reload_pulse();
        s = '{8'h01, 8'h01};
        send_stream(s, 1'b0);
        check("oversize_error", 32'(bif.error), 1);
        bif.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bif.in_valid = 1'b0;
        check("oversize_ready", 32'(bif.in_ready), 0);
        check("oversize_stuck", 32'(bif.error), 1);

        // Zero-length load, then a one-byte load after reload.
        reload_pulse();
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 1'b0);
        wait_finish("zero");
        reload_pulse();
        s = '{8'h00, 8'h01, 8'h7E, 8'h7E};
        send_stream(s, 1'b0);
        wait_finish("one");

        // Random streams with random gaps and ignored reload pulses mid-stream.
        for (int t = 0; t < 20; t++) begin
            int r;
            reload_pulse();
            r = int'($urandom_range(0, 9));
            s = {};
            if (r == 0) begin
                len = int'($urandom_range(DEPTH + 1, 65535));
                s.push_back(8'(len / 256));
                s.push_back(8'(len % 256));
            end else begin
                len = int'($urandom_range(0, 12));
                s.push_back(8'(len / 256));
                s.push_back(8'(len % 256));
                sum = 0;
                for (int i = 0; i < len; i++) begin
                    s.push_back(8'($urandom));
                    sum = sum + int'(s[2 + i]);
                end
                if (r <= 7) s.push_back(8'(sum % 256));
                else s.push_back(8'(sum % 256) ^ 8'($urandom_range(1, 255)));
            end
            send_stream(s, 1'($urandom_range(0, 1)));
            wait_finish("rand");
        end

        // Full-depth load of 255-i at address i, then sweep the written RAM.
        reload_pulse();
        wr_base = n_writes;
        s = '{8'h01, 8'h00};
        sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            s.push_back(8'(255 - i));
            sum = sum + (255 - i);
        end
        s.push_back(8'(sum % 256));
        send_stream(s, 1'b0);
        wait_finish("full");
        check("full_count", 32'(n_writes - wr_base), 256);
        for (int i = 0; i < DEPTH; i++) check("ram_sweep", 32'(ram[i]), 32'(255 - i));

        // Stalled load aborted by an asynchronous reset with a write pending.
        reload_pulse();
        wr_base = n_writes;
        exp_wr.push_back({16'd0, 8'h01});
        exp_wr.push_back({16'd1, 8'h02});
        send_byte(8'h00); @(negedge clk);
        send_byte(8'h04); @(negedge clk);
        send_byte(8'h01); @(negedge clk);
        send_byte(8'h02); @(negedge clk);
        bif.in_data  = 8'h03;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        check("pend_we", 32'(bif.mem_we), 1);
        check("pend_addr", 32'(bif.mem_addr), 2);
        #1 reset = 1'b1;
        #1;
        check("abort_we", 32'(bif.mem_we), 0);
        check("abort_addr", 32'(bif.mem_addr), 0);
        check("abort_wdata", 32'(bif.mem_wdata), 0);
        check("abort_hold", 32'(bif.cpu_hold), 1);
        check("abort_ready", 32'(bif.in_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_writes", 32'(n_writes - wr_base), 2);
        check("abort_ram2", 32'(ram[2]), 32'hFD);
        check("abort_wr_left", 32'(exp_wr.size()), 0);
        check("status_left", 32'(exp_st.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of mem_addr.
REQ-002 Parameter DATA_WIDTH, default 8: width of in_data and mem_wdata.
REQ-003 Parameter LOAD_DEPTH, default 256: maximum payload byte count accepted; must not exceed 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a boot-stream byte is present on in_data.
REQ-007 in_data  input  DATA_WIDTH  boot-stream byte.
REQ-008 in_ready  output  1  the loader accepts in_data this cycle.
REQ-009 reload  input  1  single-cycle request to restart loading from DONE or ERROR.
REQ-010 mem_addr  output  ADDR_WIDTH  RAM write address.
REQ-011 mem_wdata  output  DATA_WIDTH  RAM write data.
REQ-012 mem_we  output  1  RAM write strobe; one cycle per payload byte.
REQ-013 cpu_hold  output  1  holds the CPU timer/decoder paused while high.
REQ-014 done  output  1  load completed with a good checksum.
REQ-015 error  output  1  load aborted: bad length or bad checksum.

Function
REQ-016 A byte is accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-017 in_ready shall be 1 only in states LEN_HI, LEN_LO, DATA and CSUM.
REQ-018 The stream format shall be: length high byte, length low byte, length payload bytes, then one checksum byte.
REQ-019 State LEN_HI: on accept, store the byte as length[15:8] and go to LEN_LO.
REQ-020 State LEN_LO: on accept, store length[7:0]; clear the running sum and write pointer.
REQ-021 From LEN_LO: if length > LOAD_DEPTH go to ERROR, else if length == 0 go to CSUM, else go to DATA.
REQ-022 State DATA: on accept, register mem_addr = write pointer and mem_wdata = in_data, and pulse mem_we high on the following cycle for exactly one cycle.
REQ-023 State DATA: on accept, add the byte to the running sum modulo 2**DATA_WIDTH and increment the write pointer.
REQ-024 State DATA: after the byte with pointer == length-1 is accepted, go to CSUM; back-to-back accepts produce back-to-back mem_we pulses at consecutive addresses.
REQ-025 State CSUM: on accept, go to DONE if the byte equals the running sum, else go to ERROR; no RAM write occurs.
REQ-026 DONE: cpu_hold=0 and done=1, latched.
REQ-027 ERROR: cpu_hold=1 and error=1, latched.
REQ-028 reload=1 in DONE or ERROR shall clear done/error, set cpu_hold=1 and go to LEN_HI on the next edge; reload is ignored in all other states.
REQ-029 mem_addr and mem_wdata shall hold their last values when mem_we=0.
REQ-030 cpu_hold shall be 1 in every state other than DONE.
REQ-031 in_valid low stalls the FSM in its current state with no side effects.

Reset
REQ-032 While reset=1, regardless of clk: state=LEN_HI, cpu_hold=1, mem_we=0, done=0, error=0, mem_addr=0, mem_wdata=0, length=0, sum=0, pointer=0.
REQ-033 After reset deasserts, in_ready=1 from the first cycle.
REQ-034 Reset asserted mid-load shall abort immediately, including suppressing any pending mem_we pulse; RAM contents already written are not restored.

Verification
REQ-035 Stream 00 03 11 22 33 66 sent back-to-back -> mem_we pulses at addresses 0,1,2 with data 11,22,33; then done=1, cpu_hold=0, error=0.
REQ-036 Stream 00 02 AA 55 00 (true sum FF) -> two writes, then error=1, cpu_hold=1, done=0.
REQ-037 Stream 01 01 with LOAD_DEPTH=256 -> error=1 right after the second byte; mem_we never asserted; in_ready=0 thereafter.
REQ-038 Stream 00 00 00 -> no writes; done=1; then reload pulse followed by stream 00 01 7E 7E -> single write of 7E at address 0; done=1.
REQ-039 Stream 00 04 01 02 with in_valid toggling every other cycle, then reset asserted asynchronously between clock edges -> outputs take reset values immediately; the third payload byte is never written.
REQ-040 Full LOAD_DEPTH=256 load of bytes 255-i at address i with the correct checksum -> 256 writes at addresses 0..FF, done=1; the RAM readback sweep matches every entry.
